rv_alu1_stage: RTL

//  Parametrised ALU1 (operand-select) pipeline stage with valid/ready handshake between decode and ALU2.

---
 rtl/rv_alu1_stage_if.sv | 56 +++++
 rtl/rv_alu1_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rv_alu1_stage_if.sv
// Decode-to-ALU1 and ALU1-to-ALU2 bundle: handshake, bypass network inputs,
// decoded instruction fields and resolved operand outputs.
interface rv_alu1_stage_if #(
    parameter int unsigned IADDR_SPACE_BITS = 32,
    parameter int unsigned BP_SRCS          = 4
);
    logic                        i_flush;
    logic                        i_valid;
    logic                        o_ready;
    logic                        o_valid;
    logic                        i_ready;
    logic [BP_SRCS-1:0]          i_rs1_bp;
    logic [BP_SRCS-1:0]          i_rs2_bp;
    logic [32*BP_SRCS-1:0]       i_bp_data;
    logic [31:0]                 i_reg1_data;
    logic [31:0]                 i_reg2_data;
    logic [IADDR_SPACE_BITS-1:0] i_pc;
    logic [31:0]                 i_imm_i;
    logic [31:0]                 i_imm_j;
    logic                        i_op1_pc;
    logic                        i_op2_imm_i;
    logic                        i_op2_imm_j;
    logic                        i_inst_jal;
    logic                        i_inst_jalr;
    logic                        i_inst_mret;
    logic [IADDR_SPACE_BITS-1:0] i_ret_addr;
    logic [4:0]                  i_rd;
    logic                        i_reg_write;
    logic [31:0]                 o_op1;
    logic [31:0]                 o_op2;
    logic [31:0]                 o_reg_data1;
    logic [31:0]                 o_reg_data2;
    logic [IADDR_SPACE_BITS-1:0] o_pc;
    logic [IADDR_SPACE_BITS-1:0] o_pc_target;
    logic                        o_jump;
    logic [4:0]                  o_rd;
    logic                        o_reg_write;

    modport slave (
        input  i_flush, i_valid, i_ready, i_rs1_bp, i_rs2_bp, i_bp_data,
               i_reg1_data, i_reg2_data, i_pc, i_imm_i, i_imm_j, i_op1_pc,
               i_op2_imm_i, i_op2_imm_j, i_inst_jal, i_inst_jalr, i_inst_mret,
               i_ret_addr, i_rd, i_reg_write,
        output o_ready, o_valid, o_op1, o_op2, o_reg_data1, o_reg_data2,
               o_pc, o_pc_target, o_jump, o_rd, o_reg_write
    );

    modport master (
        output i_flush, i_valid, i_ready, i_rs1_bp, i_rs2_bp, i_bp_data,
               i_reg1_data, i_reg2_data, i_pc, i_imm_i, i_imm_j, i_op1_pc,
               i_op2_imm_i, i_op2_imm_j, i_inst_jal, i_inst_jalr, i_inst_mret,
               i_ret_addr, i_rd, i_reg_write,
        input  o_ready, o_valid, o_op1, o_op2, o_reg_data1, o_reg_data2,
               o_pc, o_pc_target, o_jump, o_rd, o_reg_write
    );
endinterface

// File: rtl/rv_alu1_stage.sv
// ALU1 operand-select stage: registers one decoded instruction, resolves rs1/rs2
// through a priority bypass network, holds them across stalls, forms ALU operands and jump target.
module rv_alu1_stage #(
    parameter int unsigned IADDR_SPACE_BITS = 32,
    parameter int unsigned BP_SRCS          = 4
) (
    input logic           i_clk,
    input logic           i_reset_n,
    rv_alu1_stage_if.slave bus
);
    localparam int unsigned IA = IADDR_SPACE_BITS;

    logic          valid_q, valid_d;
    logic          held_q, held_d;
    logic [4:0]    rd_q, rd_d;
    logic          jal_q, jal_d;
    logic          jalr_q, jalr_d;
    logic          mret_q, mret_d;
    logic          reg_write_q, reg_write_d;

    logic [IA-1:0] pc_q, pc_d;
    logic [IA-1:0] ret_addr_q, ret_addr_d;
    logic [31:0]   imm_i_q, imm_i_d;
    logic [31:0]   imm_j_q, imm_j_d;
    logic          op1_pc_q, op1_pc_d;
    logic          op2_imm_i_q, op2_imm_i_d;
    logic          op2_imm_j_q, op2_imm_j_d;
    logic [31:0]   hold1_q, hold1_d;
    logic [31:0]   hold2_q, hold2_d;

    logic          ready;
    logic          load;
    logic [31:0]   live1, live2;
    logic [31:0]   rs1, rs2;
    logic [IA-1:0] jalr_sum;
    logic [IA-1:0] jal_sum;

    assign ready = !valid_q || bus.i_ready;
    assign load  = bus.i_valid && ready;

    // Scan from the oldest source down so the lowest set index wins.
    always_comb begin
        live1 = bus.i_reg1_data;
        live2 = bus.i_reg2_data;
        for (int k = int'(BP_SRCS) - 1; k >= 0; k--) begin
            if (bus.i_rs1_bp[k]) live1 = bus.i_bp_data[32*k +: 32];
            if (bus.i_rs2_bp[k]) live2 = bus.i_bp_data[32*k +: 32];
        end
    end

    always_comb begin
        valid_d     = valid_q;
        held_d      = held_q;
        rd_d        = rd_q;
        jal_d       = jal_q;
        jalr_d      = jalr_q;
        mret_d      = mret_q;
        reg_write_d = reg_write_q;
        pc_d        = pc_q;
        ret_addr_d  = ret_addr_q;
        imm_i_d     = imm_i_q;
        imm_j_d     = imm_j_q;
        op1_pc_d    = op1_pc_q;
        op2_imm_i_d = op2_imm_i_q;
        op2_imm_j_d = op2_imm_j_q;
        hold1_d     = hold1_q;
        hold2_d     = hold2_q;
        if (bus.i_flush) begin
            valid_d     = 1'b0;
            held_d      = 1'b0;
            jal_d       = 1'b0;
            jalr_d      = 1'b0;
            mret_d      = 1'b0;
            reg_write_d = 1'b0;
        end else begin
            valid_d = load || (valid_q && !bus.i_ready);
            if (bus.i_ready) begin
                held_d = 1'b0;
            end else if (valid_q && !held_q) begin
                // Capture forwarded values before their producers move on.
                held_d  = 1'b1;
                hold1_d = live1;
                hold2_d = live2;
            end
            if (load) begin
                rd_d        = bus.i_rd;
                jal_d       = bus.i_inst_jal;
                jalr_d      = bus.i_inst_jalr;
                mret_d      = bus.i_inst_mret;
                reg_write_d = bus.i_reg_write;
                pc_d        = bus.i_pc;
                ret_addr_d  = bus.i_ret_addr;
                imm_i_d     = bus.i_imm_i;
                imm_j_d     = bus.i_imm_j;
                op1_pc_d    = bus.i_op1_pc;
                op2_imm_i_d = bus.i_op2_imm_i;
                op2_imm_j_d = bus.i_op2_imm_j;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            valid_q     <= 1'b0;
            held_q      <= 1'b0;
            rd_q        <= 5'd0;
            jal_q       <= 1'b0;
            jalr_q      <= 1'b0;
            mret_q      <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            held_q      <= held_d;
            rd_q        <= rd_d;
            jal_q       <= jal_d;
            jalr_q      <= jalr_d;
            mret_q      <= mret_d;
            reg_write_q <= reg_write_d;
        end
    end

    always_ff @(posedge i_clk) begin
        pc_q        <= pc_d;
        ret_addr_q  <= ret_addr_d;
        imm_i_q     <= imm_i_d;
        imm_j_q     <= imm_j_d;
        op1_pc_q    <= op1_pc_d;
        op2_imm_i_q <= op2_imm_i_d;
        op2_imm_j_q <= op2_imm_j_d;
        hold1_q     <= hold1_d;
        hold2_q     <= hold2_d;
    end

    always_comb begin
        rs1      = held_q ? hold1_q : live1;
        rs2      = held_q ? hold2_q : live2;
        jalr_sum = rs1[IA-1:0] + imm_i_q[IA-1:0];
        jal_sum  = pc_q + imm_j_q[IA-1:0];
    end

    assign bus.o_ready     = ready;
    assign bus.o_valid     = valid_q;
    assign bus.o_reg_data1 = rs1;
    assign bus.o_reg_data2 = rs2;
    assign bus.o_op1       = op1_pc_q ? 32'(pc_q) : rs1;
    assign bus.o_op2       = op2_imm_i_q ? imm_i_q : (op2_imm_j_q ? imm_j_q : rs2);
    assign bus.o_pc        = pc_q;
    assign bus.o_pc_target = mret_q ? ret_addr_q :
                             (jalr_q ? {jalr_sum[IA-1:1], 1'b0} : jal_sum);
    assign bus.o_jump      = valid_q && (jal_q || jalr_q || mret_q);
    assign bus.o_rd        = rd_q;
    assign bus.o_reg_write = valid_q && reg_write_q;
endmodule
